// File: rtl/control_unit_if.sv
// control_unit_if
//   Bundles the signals exchanged between the control unit and the datapath
//   and memory of the CS147DV processor.
//
//   Signals:
//     INSTRUCTION [31:0] IR contents, datapath -> control
//     ZERO               ALU zero flag, datapath -> control
//     CTRL        [31:0] datapath control word, control -> datapath
//     READ               memory read strobe, control -> memory
//     WRITE              memory write strobe, control -> memory
//     STATE       [2:0]  current sequencer state code (debug)
//
//   Modports:
//     master  the control unit (drives CTRL/READ/WRITE/STATE)
//     slave   the datapath/memory side
//
//   Timing contract: there is no valid/ready handshake on this bus. The
//   sequencer runs a fixed five-cycle cadence; the datapath must hold
//   INSTRUCTION stable from DECODE through WB, and memory must return fetch
//   data within the FETCH cycle so the IR can capture it on the
//   FETCH->DECODE edge. ZERO is consumed combinationally during WB.
interface control_unit_if;
    logic [31:0] INSTRUCTION;
    logic        ZERO;
    logic [31:0] CTRL;
    logic        READ;
    logic        WRITE;
    logic [2:0]  STATE;

    modport master (
        input  INSTRUCTION,
        input  ZERO,
        output CTRL,
        output READ,
        output WRITE,
        output STATE
    );

    modport slave (
        output INSTRUCTION,
        output ZERO,
        input  CTRL,
        input  READ,
        input  WRITE,
        input  STATE
    );
endinterface

// File: rtl/control_unit.sv
// control_unit
//   Five-state instruction sequencer (FETCH, DECODE, EXE, MEM, WB) for the
//   CS147DV processor. Produces the 32-bit datapath control word and the
//   memory strobes as a combinational decode of the current state and the
//   instruction register.
//
//   Ports:
//     CLK   processor clock, state advances on the rising edge
//     RST   asynchronous active-low reset; forces FETCH and zeroes all outputs
//     bus   control_unit_if.master (INSTRUCTION, ZERO in; CTRL, READ, WRITE,
//           STATE out)
//
//   CTRL bit map:
//     0 pc_load | 3:1 pc_sel_3..1 | 4 ir_load | 7 r1_sel_1 | 8 reg_r
//     9 reg_w | 12:10 wa_sel_3..1 | 15:13 wd_sel_3..1 | 16 sp_load
//     17 op1_sel_1 | 21:18 op2_sel_4..1 | 27:22 alu_oprn | 28 ma_sel_1
//     29 ma_sel_2 | 30 md_sel_1 | 5, 6, 31 reserved (0)
module control_unit (
    input  logic           CLK,
    input  logic           RST,
    control_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_MULI  = 6'h1d;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_JMP   = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_PUSH  = 6'h1b;
    localparam logic [5:0] OP_POP   = 6'h1c;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_MUL = 6'h2c;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;
    localparam logic [5:0] FN_SLL = 6'h01;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;

    // ALU operation codes
    localparam logic [5:0] ALU_ADD = 6'h01;
    localparam logic [5:0] ALU_SUB = 6'h02;
    localparam logic [5:0] ALU_MUL = 6'h03;
    localparam logic [5:0] ALU_SHR = 6'h04;
    localparam logic [5:0] ALU_SHL = 6'h05;
    localparam logic [5:0] ALU_AND = 6'h06;
    localparam logic [5:0] ALU_OR  = 6'h07;
    localparam logic [5:0] ALU_NOR = 6'h08;
    localparam logic [5:0] ALU_SLT = 6'h09;

    state_t state;
    state_t state_next;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr_bits;

    assign opcode            = bus.INSTRUCTION[31:26];
    assign funct             = bus.INSTRUCTION[5:0];
    assign unused_instr_bits = ^bus.INSTRUCTION[25:6];

    // ---------------------------------------------------------------
    // State register and fixed-ring next-state logic
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = S_EXE;
            S_EXE:    state_next = S_MEM;
            S_MEM:    state_next = S_WB;
            S_WB:     state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // ---------------------------------------------------------------
    // Instruction classification. Anything unrecognised leaves every
    // flag low, which makes it a NOP apart from the PC+1 update.
    // ---------------------------------------------------------------
    logic       r_alu, r_shift, r_jr;
    logic       i_sext, i_zext, i_lui, i_lw, i_sw;
    logic       i_beq, i_bne, i_push, i_pop, i_jmp, i_jal;
    logic [5:0] alu_sel;

    always_comb begin
        r_alu   = 1'b0;
        r_shift = 1'b0;
        r_jr    = 1'b0;
        i_sext  = 1'b0;
        i_zext  = 1'b0;
        i_lui   = 1'b0;
        i_lw    = 1'b0;
        i_sw    = 1'b0;
        i_beq   = 1'b0;
        i_bne   = 1'b0;
        i_push  = 1'b0;
        i_pop   = 1'b0;
        i_jmp   = 1'b0;
        i_jal   = 1'b0;
        alu_sel = 6'h00;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  begin r_alu   = 1'b1; alu_sel = ALU_ADD; end
                FN_SUB:  begin r_alu   = 1'b1; alu_sel = ALU_SUB; end
                FN_MUL:  begin r_alu   = 1'b1; alu_sel = ALU_MUL; end
                FN_AND:  begin r_alu   = 1'b1; alu_sel = ALU_AND; end
                FN_OR:   begin r_alu   = 1'b1; alu_sel = ALU_OR;  end
                FN_NOR:  begin r_alu   = 1'b1; alu_sel = ALU_NOR; end
                FN_SLT:  begin r_alu   = 1'b1; alu_sel = ALU_SLT; end
                FN_SLL:  begin r_shift = 1'b1; alu_sel = ALU_SHL; end
                FN_SRL:  begin r_shift = 1'b1; alu_sel = ALU_SHR; end
                FN_JR:   r_jr = 1'b1;
                default: ;
            endcase
        end else begin
            case (opcode)
                OP_ADDI: begin i_sext = 1'b1; alu_sel = ALU_ADD; end
                OP_MULI: begin i_sext = 1'b1; alu_sel = ALU_MUL; end
                OP_SLTI: begin i_sext = 1'b1; alu_sel = ALU_SLT; end
                OP_ANDI: begin i_zext = 1'b1; alu_sel = ALU_AND; end
                OP_ORI:  begin i_zext = 1'b1; alu_sel = ALU_OR;  end
                OP_LUI:  i_lui = 1'b1;
                OP_LW:   begin i_lw   = 1'b1; alu_sel = ALU_ADD; end
                OP_SW:   begin i_sw   = 1'b1; alu_sel = ALU_ADD; end
                OP_BEQ:  begin i_beq  = 1'b1; alu_sel = ALU_SUB; end
                OP_BNE:  begin i_bne  = 1'b1; alu_sel = ALU_SUB; end
                OP_PUSH: begin i_push = 1'b1; alu_sel = ALU_SUB; end
                OP_POP:  begin i_pop  = 1'b1; alu_sel = ALU_ADD; end
                OP_JMP:  i_jmp = 1'b1;
                OP_JAL:  i_jal = 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Per-state control decode
    // ---------------------------------------------------------------
    logic       pc_load, pc_sel_1, pc_sel_2, pc_sel_3, ir_load;
    logic       r1_sel_1, reg_r, reg_w;
    logic       wa_sel_1, wa_sel_2, wa_sel_3;
    logic       wd_sel_1, wd_sel_2, wd_sel_3;
    logic       sp_load, op1_sel_1;
    logic       op2_sel_1, op2_sel_2, op2_sel_3, op2_sel_4;
    logic [5:0] alu_oprn;
    logic       ma_sel_1, ma_sel_2, md_sel_1;
    logic       read, write;
    logic       writes_reg;

    // Instructions whose WB commits a register from the ALU/immediate path
    assign writes_reg = r_alu | r_shift | i_sext | i_zext | i_lw | i_lui;

    always_comb begin
        pc_load   = 1'b0;
        pc_sel_1  = 1'b0;
        pc_sel_2  = 1'b0;
        pc_sel_3  = 1'b0;
        ir_load   = 1'b0;
        r1_sel_1  = 1'b0;
        reg_r     = 1'b0;
        reg_w     = 1'b0;
        wa_sel_1  = 1'b0;
        wa_sel_2  = 1'b0;
        wa_sel_3  = 1'b0;
        wd_sel_1  = 1'b0;
        wd_sel_2  = 1'b0;
        wd_sel_3  = 1'b0;
        sp_load   = 1'b0;
        op1_sel_1 = 1'b0;
        op2_sel_1 = 1'b0;
        op2_sel_2 = 1'b0;
        op2_sel_3 = 1'b0;
        op2_sel_4 = 1'b0;
        alu_oprn  = 6'h00;
        ma_sel_1  = 1'b0;
        ma_sel_2  = 1'b0;
        md_sel_1  = 1'b0;
        read      = 1'b0;
        write     = 1'b0;

        case (state)
            S_FETCH: begin
                ma_sel_2 = 1'b1;
                ir_load  = 1'b1;
                read     = 1'b1;
            end
            S_DECODE: begin
                reg_r    = 1'b1;
                r1_sel_1 = i_push;  // push stores R0
            end
            S_EXE: begin
                reg_r   = 1'b1;
                sp_load = i_pop;    // pop bumps SP before the memory read
            end
            S_MEM: begin
                if (i_lw) begin
                    read = 1'b1;
                end
                if (i_sw) begin
                    write = 1'b1;
                end
                if (i_push) begin
                    write    = 1'b1;
                    ma_sel_1 = 1'b1;
                    md_sel_1 = 1'b1;
                end
                if (i_pop) begin
                    read     = 1'b1;
                    ma_sel_1 = 1'b1;
                end
            end
            S_WB: begin
                pc_load  = 1'b1;
                pc_sel_1 = 1'b1;
                pc_sel_3 = 1'b1;
                if ((i_beq && bus.ZERO) || (i_bne && !bus.ZERO)) begin
                    pc_sel_2 = 1'b1;
                end
                if (r_jr) begin
                    pc_sel_1 = 1'b0;
                end
                if (i_jmp || i_jal) begin
                    pc_sel_3 = 1'b0;
                end
                reg_w    = writes_reg | i_jal | i_pop;
                wa_sel_3 = writes_reg;
                wa_sel_1 = i_sext | i_zext | i_lw | i_lui;
                wa_sel_2 = i_jal;
                wd_sel_3 = writes_reg | i_pop;
                wd_sel_2 = i_lui;
                wd_sel_1 = i_lw | i_pop;
                sp_load  = i_push;
            end
            default: ;
        endcase

        // ALU and operand selects are set in EXE and held through WB so the
        // ALU result (and ZERO) stay valid for memory addressing and branches.
        if (state == S_EXE || state == S_MEM || state == S_WB) begin
            op1_sel_1 = i_push | i_pop;
            op2_sel_1 = r_shift;
            op2_sel_2 = i_sext | i_lw | i_sw;
            op2_sel_3 = r_shift | i_push | i_pop;
            op2_sel_4 = r_alu | i_beq | i_bne;
            alu_oprn  = alu_sel;
        end
    end

    logic [31:0] ctrl;
    assign ctrl = {1'b0, md_sel_1, ma_sel_2, ma_sel_1, alu_oprn,
                   op2_sel_4, op2_sel_3, op2_sel_2, op2_sel_1, op1_sel_1,
                   sp_load, wd_sel_3, wd_sel_2, wd_sel_1,
                   wa_sel_3, wa_sel_2, wa_sel_1, reg_w, reg_r, r1_sel_1,
                   2'b00, ir_load, pc_sel_3, pc_sel_2, pc_sel_1, pc_load};

    // Reset gates the outputs directly so a mid-instruction reset drops any
    // strobe at once instead of waiting for the state register.
    assign bus.CTRL  = RST ? ctrl : 32'h0;
    assign bus.READ  = RST & read;
    assign bus.WRITE = RST & write;
    assign bus.STATE = state;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
//   Directed bench for control_unit: a table of per-instruction records is
//   stepped through all five states, followed by hand-written sequences for
//   reset (initial and mid-instruction) and jal.
`timescale 1ns/1ps
module tb_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    control_unit_if bus();

    control_unit dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Control word bit masks
    localparam logic [31:0] PC_LOAD = 32'h1 << 0;
    localparam logic [31:0] PC1     = 32'h1 << 1;
    localparam logic [31:0] PC2     = 32'h1 << 2;
    localparam logic [31:0] PC3     = 32'h1 << 3;
    localparam logic [31:0] IR      = 32'h1 << 4;
    localparam logic [31:0] R1      = 32'h1 << 7;
    localparam logic [31:0] RR      = 32'h1 << 8;
    localparam logic [31:0] RW      = 32'h1 << 9;
    localparam logic [31:0] WA1     = 32'h1 << 10;
    localparam logic [31:0] WA2     = 32'h1 << 11;
    localparam logic [31:0] WA3     = 32'h1 << 12;
    localparam logic [31:0] WD1     = 32'h1 << 13;
    localparam logic [31:0] WD2     = 32'h1 << 14;
    localparam logic [31:0] WD3     = 32'h1 << 15;
    localparam logic [31:0] SP      = 32'h1 << 16;
    localparam logic [31:0] OP1     = 32'h1 << 17;
    localparam logic [31:0] OP2_1   = 32'h1 << 18;
    localparam logic [31:0] OP2_2   = 32'h1 << 19;
    localparam logic [31:0] OP2_3   = 32'h1 << 20;
    localparam logic [31:0] OP2_4   = 32'h1 << 21;
    localparam logic [31:0] MA1     = 32'h1 << 28;
    localparam logic [31:0] MA2     = 32'h1 << 29;
    localparam logic [31:0] MD1     = 32'h1 << 30;

    localparam logic [5:0] A_ADD = 6'h01;
    localparam logic [5:0] A_SUB = 6'h02;
    localparam logic [5:0] A_MUL = 6'h03;
    localparam logic [5:0] A_SHR = 6'h04;
    localparam logic [5:0] A_SHL = 6'h05;
    localparam logic [5:0] A_AND = 6'h06;
    localparam logic [5:0] A_OR  = 6'h07;
    localparam logic [5:0] A_NOR = 6'h08;
    localparam logic [5:0] A_SLT = 6'h09;

    // Common WB patterns
    localparam logic [31:0] W_R   = RW | WA3 | WD3 | PC1 | PC3;
    localparam logic [31:0] W_I   = RW | WA3 | WA1 | WD3 | PC1 | PC3;
    localparam logic [31:0] W_NOP = PC1 | PC3;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic [31:0] e;      // operand/ALU fields held EXE..WB
        logic [31:0] dec_x;  // extra bits in DECODE
        logic [31:0] exe_x;  // extra bits in EXE
        logic [31:0] mem_x;  // extra bits in MEM
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] wb_x;   // extra bits in WB (besides pc_load)
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    function automatic logic [31:0] alu(input logic [5:0] c);
        return {4'b0000, c, 22'h0};
    endfunction

    function automatic logic [31:0] r_ins(input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, 5'd3, 5'd4, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op);
        return {op, 5'd1, 5'd2, 16'hfff0};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic zero,
                                input logic [31:0] e, input logic [31:0] dec_x,
                                input logic [31:0] exe_x, input logic [31:0] mem_x,
                                input logic mem_rd, input logic mem_wr,
                                input logic [31:0] wb_x);
        vec_t v;
        v.instr  = instr;
        v.zero   = zero;
        v.e      = e;
        v.dec_x  = dec_x;
        v.exe_x  = exe_x;
        v.mem_x  = mem_x;
        v.mem_rd = mem_rd;
        v.mem_wr = mem_wr;
        v.wb_x   = wb_x;
        return v;
    endfunction

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", what, act, exp);
        end
    endtask

    // Call just after a rising edge with the DUT in FETCH; returns just after
    // the WB->FETCH edge.
    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] exp_ctrl;
        logic [1:0]  exp_rw;
        bus.INSTRUCTION = v.instr;
        bus.ZERO        = v.zero;
        for (int s = 0; s < 5; s++) begin
            case (s)
                0:       begin exp_ctrl = MA2 | IR;              exp_rw = 2'b10; end
                1:       begin exp_ctrl = RR | v.dec_x;          exp_rw = 2'b00; end
                2:       begin exp_ctrl = RR | v.e | v.exe_x;    exp_rw = 2'b00; end
                3:       begin exp_ctrl = v.e | v.mem_x;         exp_rw = {v.mem_rd, v.mem_wr}; end
                default: begin exp_ctrl = v.e | PC_LOAD | v.wb_x; exp_rw = 2'b00; end
            endcase
            @(negedge clk);
            check($sformatf("v%0d s%0d state", idx, s), {29'h0, bus.STATE}, s);
            check($sformatf("v%0d s%0d ctrl", idx, s), bus.CTRL, exp_ctrl);
            check($sformatf("v%0d s%0d read/write", idx, s), {30'h0, bus.READ, bus.WRITE}, {30'h0, exp_rw});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vecs[0]  = mk(r_ins(6'h20), 1'b0, OP2_4 | alu(A_ADD), 0, 0, 0, 1'b0, 1'b0, W_R);
        vecs[1]  = mk(r_ins(6'h22), 1'b0, OP2_4 | alu(A_SUB), 0, 0, 0, 1'b0, 1'b0, W_R);
        vecs[2]  = mk(r_ins(6'h2c), 1'b0, OP2_4 | alu(A_MUL), 0, 0, 0, 1'b0, 1'b0, W_R);
        vecs[3]  = mk(r_ins(6'h27), 1'b0, OP2_4 | alu(A_NOR), 0, 0, 0, 1'b0, 1'b0, W_R);
        vecs[4]  = mk(r_ins(6'h2a), 1'b1, OP2_4 | alu(A_SLT), 0, 0, 0, 1'b0, 1'b0, W_R);
        vecs[5]  = mk(r_ins(6'h01), 1'b0, OP2_3 | OP2_1 | alu(A_SHL), 0, 0, 0, 1'b0, 1'b0, W_R);
        vecs[6]  = mk(r_ins(6'h02), 1'b0, OP2_3 | OP2_1 | alu(A_SHR), 0, 0, 0, 1'b0, 1'b0, W_R);
        vecs[7]  = mk(r_ins(6'h08), 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, PC3);
        vecs[8]  = mk(r_ins(6'h3f), 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, W_NOP);
        vecs[9]  = mk(i_ins(6'h08), 1'b0, OP2_2 | alu(A_ADD), 0, 0, 0, 1'b0, 1'b0, W_I);
        vecs[10] = mk(i_ins(6'h0c), 1'b0, alu(A_AND), 0, 0, 0, 1'b0, 1'b0, W_I);
        vecs[11] = mk(i_ins(6'h0d), 1'b0, alu(A_OR), 0, 0, 0, 1'b0, 1'b0, W_I);
        vecs[12] = mk(i_ins(6'h0f), 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, W_I | WD2);
        vecs[13] = mk(i_ins(6'h23), 1'b0, OP2_2 | alu(A_ADD), 0, 0, 0, 1'b1, 1'b0, W_I | WD1);
        vecs[14] = mk(i_ins(6'h2b), 1'b0, OP2_2 | alu(A_ADD), 0, 0, 0, 1'b0, 1'b1, W_NOP);
        vecs[15] = mk(i_ins(6'h04), 1'b1, OP2_4 | alu(A_SUB), 0, 0, 0, 1'b0, 1'b0, PC1 | PC2 | PC3);
        vecs[16] = mk(i_ins(6'h04), 1'b0, OP2_4 | alu(A_SUB), 0, 0, 0, 1'b0, 1'b0, W_NOP);
        vecs[17] = mk(i_ins(6'h05), 1'b1, OP2_4 | alu(A_SUB), 0, 0, 0, 1'b0, 1'b0, W_NOP);
        vecs[18] = mk(i_ins(6'h05), 1'b0, OP2_4 | alu(A_SUB), 0, 0, 0, 1'b0, 1'b0, PC1 | PC2 | PC3);
        vecs[19] = mk(i_ins(6'h1b), 1'b0, OP1 | OP2_3 | alu(A_SUB), R1, 0, MA1 | MD1, 1'b0, 1'b1, SP | W_NOP);
        vecs[20] = mk(i_ins(6'h1c), 1'b0, OP1 | OP2_3 | alu(A_ADD), 0, SP, MA1, 1'b1, 1'b0, RW | WD3 | WD1 | PC1 | PC3);
        vecs[21] = mk(i_ins(6'h03), 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, RW | WA2 | PC1);
        vecs[22] = mk(i_ins(6'h02), 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, PC1);
        vecs[23] = mk(i_ins(6'h3e), 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, W_NOP);

        // Reset held for three cycles
        bus.INSTRUCTION = 32'h0;
        bus.ZERO        = 1'b0;
        rst             = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ctrl", bus.CTRL, 32'h0);
        check("reset read/write", {30'h0, bus.READ, bus.WRITE}, 32'h0);
        check("reset state", {29'h0, bus.STATE}, 32'h0);

        // Release between edges: FETCH outputs appear without a clock
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("release ctrl", bus.CTRL, MA2 | IR);
        check("release read", {31'h0, bus.READ}, 32'h1);
        check("release state", {29'h0, bus.STATE}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset mid-instruction during sw MEM
        bus.INSTRUCTION = i_ins(6'h2b);
        bus.ZERO        = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("sw mem write", {31'h0, bus.WRITE}, 32'h1);
        check("sw mem state", {29'h0, bus.STATE}, 32'd3);
        rst = 1'b0;
        #1;
        check("abort write", {31'h0, bus.WRITE}, 32'h0);
        check("abort ctrl", bus.CTRL, 32'h0);
        check("abort state", {29'h0, bus.STATE}, 32'h0);
        @(posedge clk);
        #1;
        check("abort held state", {29'h0, bus.STATE}, 32'h0);
        check("abort held ctrl", bus.CTRL, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rerelease ctrl", bus.CTRL, MA2 | IR);

        // jal immediately after the aborted instruction
        run_vec(vecs[21], 100);
        // and a following lw to confirm the ring resumes normally
        run_vec(vecs[13], 101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Five-state instruction sequencer for the CS147DV processor. It drives the 32-bit control word that steers the datapath's muxes, register loads, register-file strobes and ALU operation. It also drives the memory READ/WRITE strobes, and consumes the datapath's INSTRUCTION and ZERO outputs. It is the control-side counterpart of the datapath; processor top-level connects CTRL, INSTRUCTION and ZERO directly between the two.

## Interface
Parameters: none. Opcode, funct and ALU codes come from `prj_definition.v`.

Ports:
- CLK  input  1  processor clock; all state changes on rising edge
- RST  input  1  reset, asynchronous, active-low
- INSTRUCTION  input  32  IR contents from datapath
- ZERO  input  1  ALU zero flag from datapath
- CTRL  output  32  datapath control word (bit map below)
- READ  output  1  memory read strobe
- WRITE  output  1  memory write strobe
- STATE  output  3  current state code, for debug

CTRL bits:
- 0 pc_load
- 1/2/3 pc_sel_1/2/3
- 4 ir_load
- 7 r1_sel_1
- 8 reg_r
- 9 reg_w
- 10/11/12 wa_sel_1/2/3
- 13/14/15 wd_sel_1/2/3
- 16 sp_load
- 17 op1_sel_1
- 18–21 op2_sel_1..4
- 27:22 alu_oprn
- 28 ma_sel_1
- 29 ma_sel_2
- 30 md_sel_1
- 5, 6, 31 reserved, always 0

## Operation
State machine is a fixed ring: FETCH(0) → DECODE(1) → EXE(2) → MEM(3) → WB(4) → FETCH. There are no stalls, and codes 5–7 go to FETCH. Outputs are a combinational decode of state and INSTRUCTION.
- FETCH:
  - ma_sel_2=1, READ=1, ir_load=1; all else 0.
- DECODE:
  - reg_r=1.
  - r1_sel_1=1 for push only, which reads R0.
- EXE: reg_r=1, and ALU/operand fields are set per instruction. These fields are held unchanged through MEM and WB.
  - R-type arithmetic/logic: op2_sel_4=1, alu_oprn from funct (add, sub, mul, and, or, nor, slt).
  - sll/srl: op2_sel_4=0, op2_sel_3=1, op2_sel_1=1 (shamt).
  - addi/muli/slti: op2_sel_2=1 (sign-extend), op2_sel_3=0, op2_sel_4=0.
  - andi/ori: op2_sel_2=0 (zero-extend).
  - lw/sw: add with sign-extended immediate.
  - beq/bne: sub with op2_sel_4=1.
  - push: op1_sel_1=1, op2 = constant 1, sub.
  - pop: op1_sel_1=1, op2 = constant 1, add, sp_load=1.
- MEM:
  - lw: READ=1, ma_sel_1=0, ma_sel_2=0.
  - sw: WRITE=1, md_sel_1=0.
  - push: WRITE=1, ma_sel_1=1, md_sel_1=1.
  - pop: READ=1, ma_sel_1=1.
  - All other instructions: strobes 0.
- WB: pc_load=1 always.
  - Default next PC is PC+1: pc_sel_1=1, pc_sel_2=0, pc_sel_3=1.
  - Branch taken (beq with ZERO=1, bne with ZERO=0): pc_sel_2=1, pc_sel_3=1.
  - jr: pc_sel_1=0, pc_sel_2=0, pc_sel_3=1.
  - jmp/jal: pc_sel_3=0.
  - reg_w=1 for R-type except jr, I-type ALU ops, lw, lui, jal and pop.
  - R-type destination is rd: wa_sel_3=1, wa_sel_1=0.
  - I-type/lw/lui destination is rt: wa_sel_3=1, wa_sel_1=1.
  - jal destination is R31: wa_sel_3=0, wa_sel_2=1.
  - pop destination is R0: wa_sel_3=0, wa_sel_2=0.
  - Write data:
    - ALU result: wd_sel_3=1, wd_sel_2=0, wd_sel_1=0.
    - lw/pop (memory data): wd_sel_1=1.
    - lui: wd_sel_2=1.
    - jal (PC+1): wd_sel_3=0.
  - push: sp_load=1.
- Unknown opcode or funct is a NOP: only the default PC+1 update in WB.
- READ and WRITE are never both 1.

## Timing
- RST=0 asynchronously forces state to FETCH and CTRL, READ and WRITE to 0, regardless of CLK. This also applies mid-instruction; the partial instruction is abandoned with no register or memory commit.
- The first FETCH outputs appear combinationally when RST rises. The first state advance is on the next rising CLK.
- Each instruction takes exactly 5 cycles, and pc_load pulses once per instruction, in WB.
- ZERO is sampled combinationally in WB. It is valid because the ALU operands and operation are held from EXE.
- The IR captures memory data at the FETCH→DECODE edge. Memory must return data within the FETCH cycle.

## Test plan
- Reset:
  - Hold RST=0 for 3 cycles → CTRL=0, READ=0, WRITE=0, STATE=0.
  - Release RST → READ=1, ir_load=1, ma_sel_2=1.
  - After 5 edges → STATE=0 again.
- add (0x00, funct 0x20), traced over 5 cycles:
  - EXE: op2_sel_4=1 and alu_oprn=add.
  - WB: reg_w=1, wa_sel_3=1, wa_sel_1=0, wd_sel_3=1, pc_load=1.
- beq:
  - With ZERO=1 → WB has pc_sel_2=1, pc_sel_3=1.
  - With ZERO=0 → WB has pc_sel_1=1, pc_sel_2=0.
  - bne gives the inverse result for the same ZERO values.
- lw then sw:
  - lw MEM: READ=1, ma_sel_2=0; WB: wd_sel_1=1, wa_sel_1=1.
  - sw MEM: WRITE=1, md_sel_1=0; WB: reg_w=0.
- push then pop:
  - push MEM: WRITE=1, ma_sel_1=1, md_sel_1=1; WB: sp_load=1.
  - pop EXE: sp_load=1, alu_oprn=add; MEM: READ=1; WB: reg_w=1, wa_sel_3=0, wa_sel_2=0.
- Reset and jal:
  - Assert RST=0 during MEM of sw → WRITE drops to 0 immediately, STATE=0.
  - jal WB: pc_sel_3=0, wa_sel_2=1, wd_sel_3=0, reg_w=1.
